lcd_bus_receiver: RTL and testbench
===================================

// Module: lcd_bus_receiver
// PURPOSE
//  Receiving end of the 4-bit HD44780-style LCD bus driven by the LCD controller
//  (data nibble, enable, register select, read/write, StrataFlash control).
//  Samples the bus, validates each enable strobe and rebuilds 4-bit-mode nibble
//  pairs into command/data bytes, including the 8-bit power-up init sequence.
//  Sits at the far end of the LCD bus as a bus checker and display model. It is
//  used in simulation and as an on-chip monitor.
// PARAMETERS
//  MIN_E_HIGH  12     min enable-high width, in Clock cycles (240 ns at 50 MHz)
//  TIMEOUT     50000  max Clock cycles from high-nibble fall to low-nibble fall
//  CNT_W       16     width of the pulse and timeout counters; must hold TIMEOUT
// PORTS
//  Clock                    in   1  system clock; all logic on the rising edge
//  Reset                    in   1  asynchronous reset, active-low (0 = reset)
//  iLCD_Data                in   4  LCD data nibble, DB7..DB4
//  iLCD_Enabled             in   1  LCD E strobe; data is latched on its falling edge
//  iLCD_RegisterSelect      in   1  RS: 0 = command, 1 = character data
//  iLCD_ReadWrite           in   1  RW: 0 = write, 1 = read
//  iLCD_StrataFlashControl  in   1  1 = flash disabled, so the LCD owns the bus
//  oByte                    out  8  reassembled byte; held until the next oValid
//  oRS                      out  1  RS that belongs to oByte
//  oValid                   out  1  one-cycle pulse when oByte/oRS update
//  oMode4                   out  1  1 after the switch to 4-bit mode is seen
//  oErrShort                out  1  pulse: E-high width was < MIN_E_HIGH
//  oErrRS                   out  1  pulse: RS differs between a nibble pair
//  oErrTimeout              out  1  pulse: low nibble did not arrive in time
// BEHAVIOUR
//  - Reset=0 (async): state INIT8. All outputs and counters go to 0.
//  - Input sync: every bus input passes through the same 2-flop synchroniser, so
//    data stays aligned with E. A fall is a synced E going 1->0.
//  - E-high counter: counts cycles while synced E=1 and saturates at
//    2^CNT_W-1. It clears on the fall.
//  - Strobe qualification, at the fall:
//    * count < MIN_E_HIGH: discard the strobe, pulse oErrShort, no state change.
//    * RW=1 or StrataFlashControl=0: ignore the strobe silently, no state change.
//    * Otherwise it is a valid strobe, using the synced Data and RS from the
//      cycle before the fall.
//  - FSM states:
//    * INIT8: a valid strobe emits oByte={nibble,4'h0} and oRS=RS with oValid.
//      If RS=0 and nibble==4'h2, go to HI and set oMode4=1, which is sticky
//      until reset. Otherwise stay in INIT8.
//    * HI: a valid strobe latches the high nibble and its RS. Go to LO and load
//      the timeout counter with 0.
//    * LO: the timeout counter increments each cycle.
//      - A valid strobe with matching RS emits oByte={hi,nibble}, oRS and
//        oValid, then goes to HI.
//      - A valid strobe with RS mismatch pulses oErrRS, emits no byte, goes to HI.
//      - If the counter reaches TIMEOUT first, pulse oErrTimeout, drop the high
//        nibble and go to HI.
//      - A valid strobe and the timeout in the same cycle: the strobe wins.
//  - Latency: oValid/error pulses assert on the 3rd rising Clock edge after the
//    raw E falls (2 sync + 1 register).
//  - No back-pressure: any consumer must take oByte on the oValid cycle.
//  - Strobes closer together than the sync latency are not required to be
//    resolved; the controller never produces them.
//  - Reset mid-byte: the pending high nibble is lost. After release the block
//    is back in INIT8 with oMode4=0.
//  - Pulse outputs are high for exactly one cycle and never overlap with each
//    other.
// TESTING
//  1. Init: nibbles 0x3,0x3,0x3,0x2 (RS=0, E 20 cycles wide) -> oValid x4,
//     bytes 30,30,30,20, oMode4=1 after the 4th.
//  2. In 4-bit mode send 0x2 then 0x8 with RS=0 -> one oValid, oByte=28, oRS=0.
//     Then send 0x4,0x1 with RS=1 -> oByte=41, oRS=1.
//  3. E pulse 5 cycles wide -> oErrShort pulse, no oValid, state unchanged.
//     A following 20-cycle pair 0x0,0x1 -> oByte=01.
//  4. High nibble 0x4 with RS=1, low nibble 0x1 with RS=0 -> oErrRS.
//     The next pair 0x0,0xC (RS=0) -> oByte=0C.
//  5. TIMEOUT=100: high nibble only, wait 120 cycles -> oErrTimeout at
//     fall+100+3. The next pair 0x3,0x8 -> oByte=38.
//  6. Drive Reset=0 between the two nibbles -> outputs 0 at once, oMode4=0.
//     Strobe 0x3 -> oByte=30 (INIT8). Also check that RW=1 strobes produce
//     no output.

Source files
------------

// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver
//   Far-end model and checker for a 4-bit HD44780-style LCD bus. All bus inputs
//   go through the same 2-flop synchroniser, so the data stays aligned with E.
//   Each falling edge of the synced E is qualified by its high width and by the
//   RW and StrataFlash lines. Valid strobes are then rebuilt into bytes. Before
//   the switch to 4-bit mode, each strobe becomes one byte {nibble, 0}. After
//   the switch, nibble pairs form {hi, lo}.
// Ports
//   Clock, Reset (async, active-low)
//   iLCD_Data[3:0], iLCD_Enabled, iLCD_RegisterSelect, iLCD_ReadWrite,
//   iLCD_StrataFlashControl : raw LCD bus
//   oByte[7:0], oRS   : last reassembled byte and its RS, held between oValid
//   oValid            : one-cycle pulse on a new byte
//   oMode4            : sticky 4-bit mode flag
//   oErrShort/oErrRS/oErrTimeout : one-cycle error pulses
module lcd_bus_receiver #(
  parameter int unsigned MIN_E_HIGH = 12,
  parameter int unsigned TIMEOUT    = 50000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] iLCD_Data,
  input  logic       iLCD_Enabled,
  input  logic       iLCD_RegisterSelect,
  input  logic       iLCD_ReadWrite,
  input  logic       iLCD_StrataFlashControl,
  output logic [7:0] oByte,
  output logic       oRS,
  output logic       oValid,
  output logic       oMode4,
  output logic       oErrShort,
  output logic       oErrRS,
  output logic       oErrTimeout
);

  localparam logic [CNT_W-1:0] MinEHigh    = CNT_W'(MIN_E_HIGH);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax      = '1;

  // Bus bundle layout: {sf, rw, rs, e, data[3:0]}
  localparam int unsigned EIdx  = 4;
  localparam int unsigned RsIdx = 5;
  localparam int unsigned RwIdx = 6;
  localparam int unsigned SfIdx = 7;

  typedef enum logic [1:0] {StInit8, StHi, StLo} state_e;

  logic [7:0]       bus_raw;
  logic [7:0]       sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] ehigh_q, ehigh_d;
  logic [CNT_W-1:0] to_q, to_d;
  state_e           state_q, state_d;
  logic [3:0]       hi_q, hi_d;
  logic             hi_rs_q, hi_rs_d;
  logic [7:0]       byte_q, byte_d;
  logic             rs_q, rs_d;
  logic             valid_q, valid_d;
  logic             mode4_q, mode4_d;
  logic             err_short_q, err_short_d;
  logic             err_rs_q, err_rs_d;
  logic             err_to_q, err_to_d;

  logic       fall, short_strobe, good_strobe;
  logic [3:0] nib;
  logic       nib_rs;

  assign bus_raw = {iLCD_StrataFlashControl, iLCD_ReadWrite, iLCD_RegisterSelect,
                    iLCD_Enabled, iLCD_Data};

  // prev_q is the synced bus one cycle earlier: its data/RS belong to the strobe
  assign fall         = prev_q[EIdx] & ~sync2_q[EIdx];
  assign short_strobe = fall & (ehigh_q < MinEHigh);
  assign good_strobe  = fall & (ehigh_q >= MinEHigh) & ~prev_q[RwIdx] & prev_q[SfIdx];
  assign nib          = prev_q[3:0];
  assign nib_rs       = prev_q[RsIdx];

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    hi_rs_d     = hi_rs_q;
    byte_d      = byte_q;
    rs_d        = rs_q;
    valid_d     = 1'b0;
    mode4_d     = mode4_q;
    err_short_d = short_strobe;
    err_rs_d    = 1'b0;
    err_to_d    = 1'b0;
    to_d        = to_q;

    if (sync2_q[EIdx]) begin
      ehigh_d = (ehigh_q == CntMax) ? ehigh_q : ehigh_q + 1'b1;
    end else begin
      ehigh_d = '0;
    end

    unique case (state_q)
      StInit8: begin
        if (good_strobe) begin
          byte_d  = {nib, 4'h0};
          rs_d    = nib_rs;
          valid_d = 1'b1;
          if (!nib_rs && nib == 4'h2) begin
            state_d = StHi;
            mode4_d = 1'b1;
          end
        end
      end
      StHi: begin
        if (good_strobe) begin
          hi_d    = nib;
          hi_rs_d = nib_rs;
          to_d    = '0;
          state_d = StLo;
        end
      end
      StLo: begin
        to_d = to_q + 1'b1;
        if (good_strobe) begin
          state_d = StHi;
          if (nib_rs == hi_rs_q) begin
            byte_d  = {hi_q, nib};
            rs_d    = nib_rs;
            valid_d = 1'b1;
          end else begin
            err_rs_d = 1'b1;
          end
        end else if (to_q >= TimeoutLast && !short_strobe) begin
          // A coinciding short-strobe pulse defers the timeout by one cycle
          // so the two error pulses never overlap.
          err_to_d = 1'b1;
          state_d  = StHi;
        end
      end
      default: state_d = StInit8;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      ehigh_q     <= '0;
      to_q        <= '0;
      state_q     <= StInit8;
      hi_q        <= '0;
      hi_rs_q     <= 1'b0;
      byte_q      <= '0;
      rs_q        <= 1'b0;
      valid_q     <= 1'b0;
      mode4_q     <= 1'b0;
      err_short_q <= 1'b0;
      err_rs_q    <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      sync1_q     <= bus_raw;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      ehigh_q     <= ehigh_d;
      to_q        <= to_d;
      state_q     <= state_d;
      hi_q        <= hi_d;
      hi_rs_q     <= hi_rs_d;
      byte_q      <= byte_d;
      rs_q        <= rs_d;
      valid_q     <= valid_d;
      mode4_q     <= mode4_d;
      err_short_q <= err_short_d;
      err_rs_q    <= err_rs_d;
      err_to_q    <= err_to_d;
    end
  end

  assign oByte       = byte_q;
  assign oRS         = rs_q;
  assign oValid      = valid_q;
  assign oMode4      = mode4_q;
  assign oErrShort   = err_short_q;
  assign oErrRS      = err_rs_q;
  assign oErrTimeout = err_to_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Bench for lcd_bus_receiver: directed scenarios followed by random strobes,
// all predicted by a strobe-level model of the LCD byte protocol.
module tb_lcd_bus_receiver;

  localparam int unsigned MinEHigh = 12;
  localparam int unsigned Timeout  = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] data = 4'h0;
  logic       e = 1'b0, rs = 1'b0, rw = 1'b0, sf = 1'b1;
  logic [7:0] o_byte;
  logic       o_rs, o_valid, o_mode4, o_err_short, o_err_rs, o_err_to;

  int total = 0;
  int bad = 0;

  // Protocol model state
  bit         m_mode4 = 0;
  bit         m_pend = 0;
  logic [3:0] m_hi = 4'h0;
  bit         m_hirs = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_rs = 0;
  longint     t_fall = 0;

  lcd_bus_receiver #(
    .MIN_E_HIGH(MinEHigh),
    .TIMEOUT   (Timeout),
    .CNT_W     (16)
  ) dut (
    .Clock                  (clk),
    .Reset                  (rst_n),
    .iLCD_Data              (data),
    .iLCD_Enabled           (e),
    .iLCD_RegisterSelect    (rs),
    .iLCD_ReadWrite         (rw),
    .iLCD_StrataFlashControl(sf),
    .oByte                  (o_byte),
    .oRS                    (o_rs),
    .oValid                 (o_valid),
    .oMode4                 (o_mode4),
    .oErrShort              (o_err_short),
    .oErrRS                 (o_err_rs),
    .oErrTimeout            (o_err_to)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=no finish required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one E strobe, predict it with the model, and check the outcome.
  task automatic strobe(input string tag, input logic [3:0] nib, input logic r_s,
                        input logic r_w, input logic s_f, input int width);
    bit ex_valid, ex_short, ex_rs;
    int n_valid, n_short, n_rs, n_to, first_k;
    logic [7:0] c_byte;
    logic c_rs;
    ex_valid = 0; ex_short = 0; ex_rs = 0;
    if (width < int'(MinEHigh)) begin
      ex_short = 1;
    end else if (r_w || !s_f) begin
      ex_valid = 0;
    end else if (!m_mode4) begin
      ex_valid = 1;
      m_byte = {nib, 4'h0};
      m_rs = r_s;
      if (!r_s && nib == 4'h2) m_mode4 = 1;
    end else if (!m_pend) begin
      m_pend = 1; m_hi = nib; m_hirs = r_s;
    end else begin
      m_pend = 0;
      if (r_s == m_hirs) begin
        ex_valid = 1; m_byte = {m_hi, nib}; m_rs = r_s;
      end else begin
        ex_rs = 1;
      end
    end

    @(posedge clk); #1;
    data = nib; rs = r_s; rw = r_w; sf = s_f;
    @(posedge clk); #1;
    e = 1'b1;
    repeat (width) @(posedge clk);
    #1;
    e = 1'b0;
    t_fall = longint'($time);

    n_valid = 0; n_short = 0; n_rs = 0; n_to = 0; first_k = 0;
    c_byte = 8'h00; c_rs = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (o_valid) begin n_valid++; c_byte = o_byte; c_rs = o_rs; end
      if (o_err_short) n_short++;
      if (o_err_rs) n_rs++;
      if (o_err_to) n_to++;
      if ((o_valid || o_err_short || o_err_rs || o_err_to) && first_k == 0) first_k = k;
    end
    check({tag, ".valid"}, n_valid, ex_valid);
    check({tag, ".errshort"}, n_short, ex_short);
    check({tag, ".errrs"}, n_rs, ex_rs);
    check({tag, ".errto"}, n_to, 0);
    check({tag, ".latency"}, first_k, (ex_valid || ex_short || ex_rs) ? 3 : 0);
    if (ex_valid) begin
      check({tag, ".pulse_byte"}, c_byte, m_byte);
      check({tag, ".pulse_rs"}, c_rs, m_rs);
    end
    check({tag, ".byte"}, o_byte, m_byte);
    check({tag, ".rs"}, o_rs, m_rs);
    check({tag, ".mode4"}, o_mode4, m_mode4);
  endtask

  initial begin
    int n_to, n_other;
    longint t_err;
    logic [3:0] r_nib;
    logic r_rs, r_rw, r_sf;
    int r_w;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset.outs", {o_byte, o_rs, o_valid, o_mode4, o_err_short, o_err_rs, o_err_to},
          '0);
    @(negedge clk);
    rst_n = 1'b1;

    // 8-bit init sequence
    strobe("init0", 4'h3, 0, 0, 1, 20);
    strobe("init1", 4'h3, 0, 0, 1, 20);
    strobe("init2", 4'h3, 0, 0, 1, 20);
    strobe("init3", 4'h2, 0, 0, 1, 20);

    // 4-bit pairs
    strobe("cmd28.hi", 4'h2, 0, 0, 1, 20);
    strobe("cmd28.lo", 4'h8, 0, 0, 1, 20);
    strobe("dat41.hi", 4'h4, 1, 0, 1, 20);
    strobe("dat41.lo", 4'h1, 1, 0, 1, 20);

    // Short E strobe, then a normal pair
    strobe("short", 4'h7, 0, 0, 1, 5);
    strobe("b01.hi", 4'h0, 0, 0, 1, 20);
    strobe("b01.lo", 4'h1, 0, 0, 1, 20);

    // RS mismatch, then recovery
    strobe("rsmis.hi", 4'h4, 1, 0, 1, 20);
    strobe("rsmis.lo", 4'h1, 0, 0, 1, 20);
    strobe("b0c.hi", 4'h0, 0, 0, 1, 20);
    strobe("b0c.lo", 4'hC, 0, 0, 1, 20);

    // Timeout after a lone high nibble
    strobe("to.hi", 4'h5, 1, 0, 1, 20);
    n_to = 0; n_other = 0; t_err = 0;
    for (int k = 9; k <= 150; k++) begin
      @(posedge clk); #1;
      if (o_err_to) begin n_to++; t_err = longint'($time); end
      if (o_valid || o_err_short || o_err_rs) n_other++;
    end
    m_pend = 0;
    check("to.count", n_to, 1);
    check("to.other", n_other, 0);
    check("to.latency", 32'((t_err - t_fall) / 10), Timeout + 3);
    strobe("b38.hi", 4'h3, 0, 0, 1, 20);
    strobe("b38.lo", 4'h8, 0, 0, 1, 20);

    // Reset between nibbles
    strobe("rst.hi", 4'h3, 0, 0, 1, 20);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst.outs", {o_byte, o_rs, o_valid, o_mode4, o_err_short, o_err_rs, o_err_to},
          '0);
    m_mode4 = 0; m_pend = 0; m_byte = 8'h00; m_rs = 0;
    @(negedge clk);
    rst_n = 1'b1;
    strobe("rst.b30", 4'h3, 0, 0, 1, 20);
    strobe("rw1", 4'h2, 0, 1, 1, 20);
    strobe("sf0", 4'h2, 0, 0, 0, 20);
    strobe("reinit", 4'h2, 0, 0, 1, 20);

    // Random strobes in 4-bit mode; a pending high nibble always gets a
    // valid low-nibble strobe next so no timeout can intervene.
    for (int i = 0; i < 60; i++) begin
      r_nib = 4'($urandom_range(0, 15));
      r_rs  = 1'($urandom_range(0, 1));
      r_rw  = ($urandom_range(0, 5) == 0);
      r_sf  = ($urandom_range(0, 5) != 0);
      r_w   = ($urandom_range(0, 5) == 0) ? 5 : int'($urandom_range(12, 24));
      if (m_pend) begin
        r_rw = 0; r_sf = 1; r_w = 20;
      end
      strobe($sformatf("rnd%0d", i), r_nib, r_rs, r_rw, r_sf, r_w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
